uart_fifo_ctrl: RTL and testbench
=================================

# uart_fifo_ctrl

Buffering controller that sequences the UART core's single-byte data register. It owns a TX FIFO and an RX FIFO and feeds bytes into the core's transmit register only while the core reports idle. It drains received bytes with exactly one read pulse per byte and collects sticky error/overrun status plus an interrupt. It sits between the bus-facing UART register file and the UART core.

## Interface
- DEPTH, 16: entries per FIFO; power of two, ≥2
- LW, $clog2(DEPTH)+1: level-count width (derived, not overridable)

- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- host_tx_we  in  1  push host_tx_data into TX FIFO
- host_tx_data  in  8  byte to transmit
- host_rx_re  in  1  pop RX FIFO head
- host_rx_data  out  8  RX FIFO head, first-word-fall-through; 0 when empty
- flush_tx / flush_rx  in  1  synchronous FIFO clear
- clr_status  in  1  clear all sticky flags
- irq_tx_en / irq_rx_en  in  1  interrupt source enables
- tx_en  in  1  transmit permitted (same signal driven to the core)
- core_we  out  1  write strobe to core data register
- core_di  out  8  byte to core
- core_re  out  1  read strobe to core data register
- core_do  in  8  core receive byte
- core_tx_idle  in  1  core transmitter idle (core tx_buf_empty)
- core_rx_valid  in  1  core holds unread byte
- core_err_framing / core_err_parity  in  1  core error levels
- tx_level / rx_level  out  LW  FIFO occupancy 0..DEPTH
- tx_full, tx_empty, rx_full, rx_empty  out  1  FIFO flags
- sts_tx_ovf, sts_rx_ovr, sts_frame, sts_parity  out  1  sticky flags
- irq  out  1  interrupt

## Operation
- Async reset: both FIFOs empty, both FSMs idle, sticky flags 0, edge-detect registers 0. Outputs during reset: core_we=0, core_re=0, core_di=0, host_rx_data=0, levels 0, tx_empty=rx_empty=1, full flags 0, irq=0.
- FIFOs: circular buffers with LW-bit pointers; full = level==DEPTH. A simultaneous push and pop always succeeds, even when full or empty-with-push; level is unchanged. A push while full without a pop is dropped. A pop while empty is ignored. Flush has priority over push/pop in the same cycle.
- Host TX push while tx_full (no pop that cycle): byte dropped, sts_tx_ovf set.
- TX FSM, states T_IDLE, T_LOAD, T_GUARD, T_BUSY:
  - T_IDLE→T_LOAD when !tx_empty && tx_en && core_tx_idle.
  - T_LOAD: core_we=1, core_di=TX head; FIFO pops at the end of the cycle; →T_GUARD.
  - T_GUARD: one cycle, letting core_tx_idle fall; →T_BUSY.
  - T_BUSY→T_IDLE when core_tx_idle=1.
  - core_we and core_di are decoded from the state register only; core_di=0 outside T_LOAD.
  - flush_tx does not abort a byte already handed to the core.
- RX FSM, states R_IDLE, R_ACK, R_GUARD:
  - R_IDLE→R_ACK when core_rx_valid.
  - R_ACK: core_re=1; core_do is pushed into the RX FIFO at the end of the cycle; →R_GUARD.
  - R_GUARD: one cycle while core_rx_valid clears; →R_IDLE.
  - If the RX FIFO is full with no same-cycle host pop, the byte is discarded, the core is still acknowledged, and sts_rx_ovr is set.
- Errors: sts_frame is set on a rising edge of core_err_framing; sts_parity is set on a rising edge of core_err_parity (both compared against the previous-cycle registered value).
- clr_status clears all four sticky flags. A set and a clear in the same cycle resolve to set.
- irq = (irq_tx_en & tx_empty & T_IDLE) | (irq_rx_en & !rx_empty) | sts_tx_ovf | sts_rx_ovr | sts_frame | sts_parity. irq is combinational from registers.

## Timing
- Host push at edge E0 into an empty TX FIFO with the core idle: T_LOAD is entered at E1, core_we is high for the cycle after E1, and the FIFO pops at E2.
- Minimum spacing between core_we pulses is 3 cycles plus the core's busy time. Back-to-back core_we is impossible by construction.
- core_rx_valid rising before edge E0: R_ACK is entered at E0, the byte is pushed at E1, and rx_empty=0 after E1. Minimum spacing between core_re pulses is 3 cycles.
- host_rx_data reflects a new head the cycle after the pop edge.
- Levels and flags update on the same edge as the push/pop they reflect.
- Reset asserted mid-transfer clears state immediately, so core_we/core_re drop asynchronously. The core is reset by the same rst.

## Test plan
- Push 0x55, 0xA3, 0x0F with core_tx_idle modelled (low 20 cycles after each core_we) -> exactly three core_we pulses carrying 0x55, 0xA3, 0x0F in order; tx_level ends at 0; irq rises when irq_tx_en=1.
- Push DEPTH+1 bytes with tx_en=0 -> tx_full=1, tx_level=DEPTH, sts_tx_ovf=1, no core_we. Then tx_en=1 -> DEPTH bytes sent, and the 17th is never sent.
- Core presents 0x3C with core_rx_valid held 1 cycle after core_re -> exactly one core_re, host_rx_data=0x3C, rx_level=1; host_rx_re -> rx_empty=1, host_rx_data=0.
- Fill RX to DEPTH, deliver one more byte -> core_re still pulses, sts_rx_ovr=1, rx_level=DEPTH. Repeat with host_rx_re in the push cycle -> byte accepted, no overrun.
- Pulse core_err_framing high, hold core_err_parity high 5 cycles -> sts_frame=1, sts_parity=1, irq=1. Assert clr_status in the same cycle as a new parity rising edge -> flag stays 1.
- Assert rst during T_BUSY with 4 bytes queued -> all outputs return to reset values asynchronously; after release, no core_we until a new push.

Source files
------------

// File: rtl/uart_fifo_ctrl.sv
// UART buffering controller: TX/RX FIFOs around the core's single-byte
// data register, with load/ack sequencing, sticky status and interrupt.
module uart_fifo_ctrl #(
    parameter  int DEPTH = 16,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          host_tx_we,
    input  logic [7:0]    host_tx_data,
    input  logic          host_rx_re,
    output logic [7:0]    host_rx_data,
    input  logic          flush_tx,
    input  logic          flush_rx,
    input  logic          clr_status,
    input  logic          irq_tx_en,
    input  logic          irq_rx_en,
    input  logic          tx_en,
    output logic          core_we,
    output logic [7:0]    core_di,
    output logic          core_re,
    input  logic [7:0]    core_do,
    input  logic          core_tx_idle,
    input  logic          core_rx_valid,
    input  logic          core_err_framing,
    input  logic          core_err_parity,
    output logic [LW-1:0] tx_level,
    output logic [LW-1:0] rx_level,
    output logic          tx_full,
    output logic          tx_empty,
    output logic          rx_full,
    output logic          rx_empty,
    output logic          sts_tx_ovf,
    output logic          sts_rx_ovr,
    output logic          sts_frame,
    output logic          sts_parity,
    output logic          irq
);

    localparam int AW = LW - 1;

    typedef enum logic [1:0] {T_IDLE, T_LOAD, T_GUARD, T_BUSY} tx_state_e;
    typedef enum logic [1:0] {R_IDLE, R_ACK, R_GUARD} rx_state_e;

    tx_state_e tx_state_q, tx_state_d;
    rx_state_e rx_state_q, rx_state_d;

    logic [7:0]    tx_mem_q [DEPTH];
    logic [7:0]    rx_mem_q [DEPTH];
    logic [LW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [LW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;

    logic tx_ovf_q, tx_ovf_d, rx_ovr_q, rx_ovr_d;
    logic frame_q, frame_d, parity_q, parity_d;
    logic err_f_q, err_p_q;

    logic tx_push_ok, tx_pop, tx_pop_ok;
    logic rx_push, rx_push_ok, rx_pop_ok;

    assign tx_level = tx_wp_q - tx_rp_q;
    assign rx_level = rx_wp_q - rx_rp_q;
    assign tx_full  = (tx_level == LW'(DEPTH));
    assign rx_full  = (rx_level == LW'(DEPTH));
    assign tx_empty = (tx_level == '0);
    assign rx_empty = (rx_level == '0);

    assign tx_pop     = (tx_state_q == T_LOAD);
    assign tx_pop_ok  = tx_pop & (~tx_empty | host_tx_we);
    assign tx_push_ok = host_tx_we & (~tx_full | tx_pop);

    assign rx_push    = (rx_state_q == R_ACK);
    assign rx_pop_ok  = host_rx_re & (~rx_empty | rx_push);
    assign rx_push_ok = rx_push & (~rx_full | host_rx_re);

    assign core_we = (tx_state_q == T_LOAD);
    assign core_di = core_we ? tx_mem_q[tx_rp_q[AW-1:0]] : 8'h00;
    assign core_re = (rx_state_q == R_ACK);

    assign host_rx_data = rx_empty ? 8'h00 : rx_mem_q[rx_rp_q[AW-1:0]];

    always_comb begin
        tx_wp_d = tx_wp_q;
        tx_rp_d = tx_rp_q;
        rx_wp_d = rx_wp_q;
        rx_rp_d = rx_rp_q;
        if (flush_tx) begin
            tx_wp_d = '0;
            tx_rp_d = '0;
        end else begin
            if (tx_push_ok) tx_wp_d = tx_wp_q + LW'(1);
            if (tx_pop_ok)  tx_rp_d = tx_rp_q + LW'(1);
        end
        if (flush_rx) begin
            rx_wp_d = '0;
            rx_rp_d = '0;
        end else begin
            if (rx_push_ok) rx_wp_d = rx_wp_q + LW'(1);
            if (rx_pop_ok)  rx_rp_d = rx_rp_q + LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!flush_tx && tx_push_ok) tx_mem_q[tx_wp_q[AW-1:0]] <= host_tx_data;
        if (!flush_rx && rx_push_ok) rx_mem_q[rx_wp_q[AW-1:0]] <= core_do;
    end

    always_comb begin
        tx_state_d = tx_state_q;
        unique case (tx_state_q)
            T_IDLE:  if (!tx_empty && tx_en && core_tx_idle) tx_state_d = T_LOAD;
            T_LOAD:  tx_state_d = T_GUARD;
            T_GUARD: tx_state_d = T_BUSY;
            T_BUSY:  if (core_tx_idle) tx_state_d = T_IDLE;
            default: tx_state_d = T_IDLE;
        endcase
    end

    always_comb begin
        rx_state_d = rx_state_q;
        unique case (rx_state_q)
            R_IDLE:  if (core_rx_valid) rx_state_d = R_ACK;
            R_ACK:   rx_state_d = R_GUARD;
            R_GUARD: rx_state_d = R_IDLE;
            default: rx_state_d = R_IDLE;
        endcase
    end

    // Sticky flags: a set in the same cycle as a clear wins.
    always_comb begin
        tx_ovf_d = (tx_ovf_q & ~clr_status)
                 | (host_tx_we & tx_full & ~tx_pop);
        rx_ovr_d = (rx_ovr_q & ~clr_status)
                 | (rx_push & rx_full & ~host_rx_re);
        frame_d  = (frame_q & ~clr_status)
                 | (core_err_framing & ~err_f_q);
        parity_d = (parity_q & ~clr_status)
                 | (core_err_parity & ~err_p_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= T_IDLE;
            rx_state_q <= R_IDLE;
            tx_wp_q    <= '0;
            tx_rp_q    <= '0;
            rx_wp_q    <= '0;
            rx_rp_q    <= '0;
            tx_ovf_q   <= 1'b0;
            rx_ovr_q   <= 1'b0;
            frame_q    <= 1'b0;
            parity_q   <= 1'b0;
            err_f_q    <= 1'b0;
            err_p_q    <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            rx_state_q <= rx_state_d;
            tx_wp_q    <= tx_wp_d;
            tx_rp_q    <= tx_rp_d;
            rx_wp_q    <= rx_wp_d;
            rx_rp_q    <= rx_rp_d;
            tx_ovf_q   <= tx_ovf_d;
            rx_ovr_q   <= rx_ovr_d;
            frame_q    <= frame_d;
            parity_q   <= parity_d;
            err_f_q    <= core_err_framing;
            err_p_q    <= core_err_parity;
        end
    end

    assign sts_tx_ovf = tx_ovf_q;
    assign sts_rx_ovr = rx_ovr_q;
    assign sts_frame  = frame_q;
    assign sts_parity = parity_q;

    assign irq = (irq_tx_en & tx_empty & (tx_state_q == T_IDLE))
               | (irq_rx_en & ~rx_empty)
               | tx_ovf_q | rx_ovr_q | frame_q | parity_q;

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Directed scoreboard bench for uart_fifo_ctrl with a simple core model.
module tb_uart_fifo_ctrl;

    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          host_tx_we = 1'b0;
    logic [7:0]    host_tx_data = 8'h00;
    logic          host_rx_re = 1'b0;
    logic [7:0]    host_rx_data;
    logic          flush_tx = 1'b0;
    logic          flush_rx = 1'b0;
    logic          clr_status = 1'b0;
    logic          irq_tx_en = 1'b0;
    logic          irq_rx_en = 1'b0;
    logic          tx_en = 1'b0;
    logic          core_we;
    logic [7:0]    core_di;
    logic          core_re;
    logic [7:0]    core_do = 8'h00;
    logic          core_tx_idle = 1'b1;
    logic          core_rx_valid = 1'b0;
    logic          core_err_framing = 1'b0;
    logic          core_err_parity = 1'b0;
    logic [LW-1:0] tx_level, rx_level;
    logic          tx_full, tx_empty, rx_full, rx_empty;
    logic          sts_tx_ovf, sts_rx_ovr, sts_frame, sts_parity;
    logic          irq;

    int passed = 0;
    int total  = 0;

    logic [7:0] got [64];
    int         got_n = 0;
    int         busy_cnt = 0;
    int         re_n = 0;

    logic [7:0] exp_q [$];
    logic [7:0] rx_q [$];
    int         rd = 0;

    uart_fifo_ctrl #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .host_tx_we(host_tx_we), .host_tx_data(host_tx_data),
        .host_rx_re(host_rx_re), .host_rx_data(host_rx_data),
        .flush_tx(flush_tx), .flush_rx(flush_rx),
        .clr_status(clr_status),
        .irq_tx_en(irq_tx_en), .irq_rx_en(irq_rx_en),
        .tx_en(tx_en),
        .core_we(core_we), .core_di(core_di), .core_re(core_re),
        .core_do(core_do), .core_tx_idle(core_tx_idle),
        .core_rx_valid(core_rx_valid),
        .core_err_framing(core_err_framing),
        .core_err_parity(core_err_parity),
        .tx_level(tx_level), .rx_level(rx_level),
        .tx_full(tx_full), .tx_empty(tx_empty),
        .rx_full(rx_full), .rx_empty(rx_empty),
        .sts_tx_ovf(sts_tx_ovf), .sts_rx_ovr(sts_rx_ovr),
        .sts_frame(sts_frame), .sts_parity(sts_parity),
        .irq(irq)
    );

    always #5 clk = ~clk;

    // Core transmitter: captures each written byte, then busy 20 cycles.
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            busy_cnt = 0;
            core_tx_idle = 1'b1;
        end else begin
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) core_tx_idle = 1'b1;
            end
            if (core_we) begin
                if (got_n < 64) got[got_n] = core_di;
                got_n++;
                core_tx_idle = 1'b0;
                busy_cnt = 20;
            end
        end
    end

    always @(negedge clk) if (core_re) re_n++;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_got(input int n, input int budget);
        int c = 0;
        while (got_n < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk("tx_sent_count", got_n, n);
    endtask

    task automatic check_sent(input int n);
        for (int i = 0; i < n; i++) begin
            if (exp_q.size() > 0) chk("tx_byte", got[rd], exp_q.pop_front());
            else chk("tx_extra_byte", got[rd], 32'hFFFF);
            rd++;
        end
    endtask

    task automatic push_tx(input logic [7:0] b, input bit expect_sent);
        host_tx_we = 1'b1;
        host_tx_data = b;
        if (expect_sent) exp_q.push_back(b);
        @(negedge clk);
        host_tx_we = 1'b0;
    endtask

    task automatic rx_deliver(input logic [7:0] b, input bit pop_in_ack);
        int n = 0;
        core_do = b;
        core_rx_valid = 1'b1;
        while (!core_re && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("core_re_seen", core_re, 1'b1);
        if (pop_in_ack) host_rx_re = 1'b1;
        @(negedge clk);
        host_rx_re = 1'b0;
        core_rx_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic pop_rx();
        host_rx_re = 1'b1;
        @(negedge clk);
        host_rx_re = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_status = 1'b1;
        @(negedge clk);
        clr_status = 1'b0;
    endtask

    initial begin
        int base;
        int re0;
        repeat (2) @(negedge clk);
        chk("rst_core_we", core_we, 1'b0);
        chk("rst_core_re", core_re, 1'b0);
        chk("rst_core_di", core_di, 8'h00);
        chk("rst_rx_data", host_rx_data, 8'h00);
        chk("rst_tx_level", tx_level, 0);
        chk("rst_rx_level", rx_level, 0);
        chk("rst_empties", {tx_empty, rx_empty, tx_full, rx_full}, 4'b1100);
        chk("rst_irq", irq, 1'b0);
        rst = 1'b0;
        tx_en = 1'b1;
        @(negedge clk);

        push_tx(8'h55, 1'b1);
        push_tx(8'hA3, 1'b1);
        push_tx(8'h0F, 1'b1);
        wait_got(3, 300);
        check_sent(3);
        repeat (30) @(negedge clk);
        chk("t1_tx_level", tx_level, 0);
        chk("t1_irq_off", irq, 1'b0);
        irq_tx_en = 1'b1;
        @(negedge clk);
        chk("t1_irq_tx", irq, 1'b1);
        irq_tx_en = 1'b0;

        tx_en = 1'b0;
        base = got_n;
        for (int i = 0; i < DEPTH + 1; i++)
            push_tx(8'h10 + 8'(i), i < DEPTH);
        chk("t2_tx_full", tx_full, 1'b1);
        chk("t2_tx_level", tx_level, DEPTH);
        chk("t2_ovf", sts_tx_ovf, 1'b1);
        chk("t2_no_we", got_n, base);
        pulse_clr();
        chk("t2_ovf_clr", sts_tx_ovf, 1'b0);
        tx_en = 1'b1;
        wait_got(base + DEPTH, 1000);
        repeat (40) @(negedge clk);
        chk("t2_17th_not_sent", got_n, base + DEPTH);
        check_sent(DEPTH);
        chk("t2_tx_empty", tx_empty, 1'b1);

        re0 = re_n;
        rx_deliver(8'h3C, 1'b0);
        rx_q.push_back(8'h3C);
        chk("t3_one_re", re_n - re0, 1);
        chk("t3_rx_data", host_rx_data, rx_q[0]);
        chk("t3_rx_level", rx_level, 1);
        irq_rx_en = 1'b1;
        @(negedge clk);
        chk("t3_irq_rx", irq, 1'b1);
        irq_rx_en = 1'b0;
        void'(rx_q.pop_front());
        pop_rx();
        chk("t3_rx_empty", rx_empty, 1'b1);
        chk("t3_rx_data_zero", host_rx_data, 8'h00);

        re0 = re_n;
        for (int i = 0; i < DEPTH; i++) begin
            rx_deliver(8'h80 + 8'(i), 1'b0);
            rx_q.push_back(8'h80 + 8'(i));
        end
        chk("t4_rx_full", rx_full, 1'b1);
        rx_deliver(8'hEE, 1'b0);
        chk("t4_re_count", re_n - re0, DEPTH + 1);
        chk("t4_ovr", sts_rx_ovr, 1'b1);
        chk("t4_rx_level", rx_level, DEPTH);
        chk("t4_head", host_rx_data, rx_q[0]);
        pulse_clr();
        chk("t4_ovr_clr", sts_rx_ovr, 1'b0);
        rx_deliver(8'hEF, 1'b1);
        void'(rx_q.pop_front());
        rx_q.push_back(8'hEF);
        chk("t4_no_ovr", sts_rx_ovr, 1'b0);
        chk("t4_level_kept", rx_level, DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            chk("t4_drain", host_rx_data, rx_q.pop_front());
            pop_rx();
        end
        chk("t4_drained", rx_empty, 1'b1);

        core_err_framing = 1'b1;
        core_err_parity = 1'b1;
        @(negedge clk);
        core_err_framing = 1'b0;
        repeat (4) @(negedge clk);
        core_err_parity = 1'b0;
        @(negedge clk);
        chk("t5_frame", sts_frame, 1'b1);
        chk("t5_parity", sts_parity, 1'b1);
        chk("t5_irq", irq, 1'b1);
        pulse_clr();
        chk("t5_cleared", {sts_frame, sts_parity, irq}, 3'b000);
        core_err_parity = 1'b1;
        clr_status = 1'b1;
        @(negedge clk);
        clr_status = 1'b0;
        core_err_parity = 1'b0;
        chk("t5_set_wins", sts_parity, 1'b1);
        chk("t5_frame_stays", sts_frame, 1'b0);
        pulse_clr();

        tx_en = 1'b0;
        base = got_n;
        push_tx(8'hC1, 1'b1);
        for (int i = 0; i < 4; i++) push_tx(8'hD0 + 8'(i), 1'b0);
        tx_en = 1'b1;
        wait_got(base + 1, 50);
        check_sent(1);
        repeat (2) @(negedge clk);
        chk("t6_queued", tx_level, 4);
        rst = 1'b1;
        #1;
        chk("t6_async_level", tx_level, 0);
        chk("t6_async_flags", {tx_empty, rx_empty, tx_full}, 3'b110);
        chk("t6_async_we", {core_we, core_re, irq}, 3'b000);
        chk("t6_async_di", core_di, 8'h00);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        base = got_n;
        repeat (40) @(negedge clk);
        chk("t6_no_we", got_n, base);
        push_tx(8'h99, 1'b1);
        wait_got(base + 1, 50);
        check_sent(1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
